cpu_alu_io_bridge: RTL and testbench

Registered bridge between the pipelined CPU's IO register set (io_control/io_status/io_datainA/io_datainB/io_dataoutA/io_dataoutB) and NCH instances of the shared super-ALU. It replaces direct wiring of CPU control bits to a single ALU. Start requests are edge-detected, and operands, type and mode are latched at launch. Results are captured per completion, and the CPU polls sticky done, timeout and error flags through io_status.

---
 rtl/cpu_alu_io_bridge.sv | 173 +++++++++++++++++
 tb/tb_cpu_alu_io_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_io_bridge.sv
// Purpose: registered bridge from the CPU IO register set to NCH super-ALU channels, with edge-triggered launch and sticky status flags.
// Latency: a launch or completion sampled at one edge is visible after that edge; the minimum round trip is 2 edges.
// Backpressure: none; a start during BUSY is dropped and flagged as overrun, and a watchdog aborts operations that stall.
module cpu_alu_io_bridge #(
  parameter int DATA_W  = 16,
  parameter int ALU_W   = 13,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    io_control,
  input  logic [DATA_W-1:0]    io_dataoutA,
  input  logic [DATA_W-1:0]    io_dataoutB,
  output logic [DATA_W-1:0]    io_status,
  output logic [DATA_W-1:0]    io_datainA,
  output logic [DATA_W-1:0]    io_datainB,
  output logic [NCH-1:0]       alu_start,
  output logic [NCH*ALU_W-1:0] alu_x,
  output logic [NCH*ALU_W-1:0] alu_y,
  output logic [2:0]           alu_type,
  output logic [1:0]           mode_type,
  input  logic [NCH-1:0]       alu_done,
  input  logic [NCH*ALU_W-1:0] alu_fout,
  input  logic [NCH*ALU_W-1:0] alu_pout
);

  // Counter must reach TIMEOUT-1; a watchdog of 0 still needs a legal 1-bit counter.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [2:0]       NCH_L    = 3'(NCH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic               start_prev;
  logic [1:0]         ch_q;
  logic [1:0]         last_ch;
  logic [ALU_W-1:0]   x_q, y_q;
  logic [2:0]         type_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   cnt;
  logic               done_f, tmo_f, bad_f, ovr_f;

  logic               start_edge, sel_ok, clr, done_hit, tmo_hit;
  logic [1:0]         sel;
  logic               launch, complete, abort, bad_set, ovr_set;
  logic [NCH*ALU_W-1:0] fout_sh, pout_sh;

  // Bits the bridge does not decode are still part of the CPU words.
  logic unused_bits;
  assign unused_bits = ^{io_control, io_dataoutA, io_dataoutB};

  assign start_edge = io_control[5] & ~start_prev;
  assign sel        = io_control[7:6];
  assign sel_ok     = ({1'b0, sel} < NCH_L);
  assign clr        = io_control[15];
  // Only the launched channel may complete an operation.
  assign done_hit   = |(alu_done & (NCH'(1) << ch_q));
  assign tmo_hit    = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign fout_sh    = alu_fout >> (ALU_W * int'(ch_q));
  assign pout_sh    = alu_pout >> (ALU_W * int'(ch_q));

  // State register; reset drops alu_start asynchronously through the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and event decode; completion takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    bad_set   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          if (sel_ok) begin
            launch    = 1'b1;
            state_nxt = BUSY;
          end else begin
            bad_set = 1'b1;
          end
        end
      end
      BUSY: begin
        ovr_set = start_edge;
        if (done_hit) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch latches, watchdog counter, result capture and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev <= 1'b0;
      ch_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      type_q     <= '0;
      mode_q     <= '0;
      cnt        <= '0;
      last_ch    <= '0;
      io_datainA <= '0;
      io_datainB <= '0;
      done_f     <= 1'b0;
      tmo_f      <= 1'b0;
      bad_f      <= 1'b0;
      ovr_f      <= 1'b0;
    end else begin
      start_prev <= io_control[5];
      if (launch) begin
        ch_q   <= sel;
        x_q    <= io_dataoutA[ALU_W-1:0];
        y_q    <= io_dataoutB[ALU_W-1:0];
        type_q <= io_control[4:2];
        mode_q <= io_control[1:0];
        cnt    <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (complete) begin
        io_datainA <= DATA_W'(fout_sh[ALU_W-1:0]);
        io_datainB <= DATA_W'(pout_sh[ALU_W-1:0]);
        last_ch    <= ch_q;
      end
      // A set event in the same cycle as the clear leaves the flag set.
      done_f <= complete | (done_f & ~clr & ~launch);
      tmo_f  <= abort    | (tmo_f  & ~clr & ~launch);
      bad_f  <= bad_set  | (bad_f  & ~clr);
      ovr_f  <= ovr_set  | (ovr_f  & ~clr);
    end
  end

  // Status word assembled from registered state only.
  always_comb begin
    io_status      = '0;
    io_status[0]   = done_f;
    io_status[1]   = (state == BUSY);
    io_status[2]   = tmo_f;
    io_status[3]   = bad_f;
    io_status[4]   = ovr_f;
    io_status[9:8] = last_ch;
  end

  // Steer the latched operands to the launched channel; other channels see zero.
  always_comb begin
    alu_start = '0;
    alu_x     = '0;
    alu_y     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(ch_q) == k) begin
        alu_start[k]             = (state == BUSY);
        alu_x[k*ALU_W +: ALU_W]  = x_q;
        alu_y[k*ALU_W +: ALU_W]  = y_q;
      end
    end
  end

  assign alu_type  = type_q;
  assign mode_type = mode_q;

endmodule

// File: tb/tb_cpu_alu_io_bridge.sv
// Bench for cpu_alu_io_bridge: two instances (watchdog 255 and 8) share all inputs.
// A transaction-level model tracks each instance and is compared every cycle.
// Directed sequences add literal expectations that pin the model.
module tb_cpu_alu_io_bridge;

  localparam int NCH = 2;
  localparam int AW  = 13;

  logic        clk, rst;
  logic [15:0] io_control, io_dataoutA, io_dataoutB;
  logic [1:0]  alu_done;
  logic [25:0] alu_fout, alu_pout;

  logic [15:0] status_a, datain_a_a, datain_b_a, status_b, datain_a_b, datain_b_b;
  logic [1:0]  start_a, start_b, mode_a, mode_b;
  logic [25:0] x_a, y_a, x_b, y_b;
  logic [2:0]  type_a, type_b;

  int total = 0;
  int fails = 0;
  int n;

  cpu_alu_io_bridge #(.DATA_W(16), .ALU_W(AW), .NCH(NCH), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .io_control(io_control), .io_dataoutA(io_dataoutA),
    .io_dataoutB(io_dataoutB), .io_status(status_a), .io_datainA(datain_a_a),
    .io_datainB(datain_b_a), .alu_start(start_a), .alu_x(x_a), .alu_y(y_a),
    .alu_type(type_a), .mode_type(mode_a), .alu_done(alu_done),
    .alu_fout(alu_fout), .alu_pout(alu_pout));

  cpu_alu_io_bridge #(.DATA_W(16), .ALU_W(AW), .NCH(NCH), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .io_control(io_control), .io_dataoutA(io_dataoutA),
    .io_dataoutB(io_dataoutB), .io_status(status_b), .io_datainA(datain_a_b),
    .io_datainB(datain_b_b), .alu_start(start_b), .alu_x(x_b), .alu_y(y_b),
    .alu_type(type_b), .mode_type(mode_b), .alu_done(alu_done),
    .alu_fout(alu_fout), .alu_pout(alu_pout));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level view of one bridge.
  typedef struct {
    bit        busy;
    int        ch;
    int        elapsed;
    bit        prev;
    bit [12:0] x, y;
    bit [2:0]  typ;
    bit [1:0]  mode;
    bit        done, tmo, bad, ovr;
    int        last_ch;
    bit [12:0] fout, pout;
  } m_t;

  m_t m [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m[i] = '{default: '0};
  endtask

  task automatic model_step(input int i, input int tmo_lim);
    bit edge_s, clr, launch, done_set, tmo_set, bad_set, ovr_set;
    int sel;
    edge_s   = io_control[5] && !m[i].prev;
    clr      = io_control[15];
    sel      = int'(io_control[7:6]);
    launch   = 0; done_set = 0; tmo_set = 0; bad_set = 0; ovr_set = 0;
    if (!m[i].busy) begin
      if (edge_s && sel < NCH) begin
        launch       = 1;
        m[i].busy    = 1;
        m[i].ch      = sel;
        m[i].x       = io_dataoutA[12:0];
        m[i].y       = io_dataoutB[12:0];
        m[i].typ     = io_control[4:2];
        m[i].mode    = io_control[1:0];
        m[i].elapsed = 0;
      end else if (edge_s) begin
        bad_set = 1;
      end
    end else begin
      m[i].elapsed++;
      if (edge_s) ovr_set = 1;
      if (alu_done[m[i].ch]) begin
        done_set     = 1;
        m[i].busy    = 0;
        m[i].fout    = alu_fout[m[i].ch*AW +: AW];
        m[i].pout    = alu_pout[m[i].ch*AW +: AW];
        m[i].last_ch = m[i].ch;
      end else if (tmo_lim != 0 && m[i].elapsed == tmo_lim) begin
        tmo_set   = 1;
        m[i].busy = 0;
      end
    end
    m[i].done = done_set || (!clr && !launch && m[i].done);
    m[i].tmo  = tmo_set  || (!clr && !launch && m[i].tmo);
    m[i].bad  = bad_set  || (!clr && m[i].bad);
    m[i].ovr  = ovr_set  || (!clr && m[i].ovr);
    m[i].prev = io_control[5];
  endtask

  task automatic compare_dut(input int i, input logic [15:0] st, input logic [15:0] da,
                             input logic [15:0] db, input logic [1:0] s, input logic [25:0] x,
                             input logic [25:0] y, input logic [2:0] ty, input logic [1:0] md);
    logic [15:0] e_st;
    logic [1:0]  e_s;
    logic [25:0] e_x, e_y;
    e_st      = '0;
    e_st[0]   = m[i].done;
    e_st[1]   = m[i].busy;
    e_st[2]   = m[i].tmo;
    e_st[3]   = m[i].bad;
    e_st[4]   = m[i].ovr;
    e_st[9:8] = 2'(m[i].last_ch);
    e_s       = m[i].busy ? 2'(1 << m[i].ch) : 2'b00;
    e_x       = 26'(m[i].x) << (AW * m[i].ch);
    e_y       = 26'(m[i].y) << (AW * m[i].ch);
    check($sformatf("dut%0d.status", i), st, e_st);
    check($sformatf("dut%0d.datainA", i), da, 16'(m[i].fout));
    check($sformatf("dut%0d.datainB", i), db, 16'(m[i].pout));
    check($sformatf("dut%0d.alu_start", i), s, e_s);
    check($sformatf("dut%0d.alu_x", i), x, e_x);
    check($sformatf("dut%0d.alu_y", i), y, e_y);
    check($sformatf("dut%0d.type_mode", i), {ty, md}, {m[i].typ, m[i].mode});
  endtask

  // Step the model on every edge (or reset) and compare just after it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 255);
      model_step(1, 8);
    end
    #1;
    compare_dut(0, status_a, datain_a_a, datain_b_a, start_a, x_a, y_a, type_a, mode_a);
    compare_dut(1, status_b, datain_a_b, datain_b_b, start_b, x_b, y_b, type_b, mode_b);
  end

  initial begin
    rst = 1'b0; io_control = '0; io_dataoutA = '0; io_dataoutB = '0;
    alu_done = '0; alu_fout = '0; alu_pout = '0;

    // Reset with a start request held high.
    #2;
    rst = 1'b1; io_control = 16'h0020; io_dataoutA = 16'h0005; io_dataoutB = 16'h0006;
    #1;
    check("rst_status", status_a, 16'h0000);
    check("rst_start", start_a, 2'b00);
    check("rst_datainA", datain_a_a, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("relaunch_start_a", start_a, 2'b01);
    check("relaunch_start_b", start_b, 2'b01);
    check("relaunch_x", x_a, 26'h0000005);
    alu_done = 2'b01; alu_fout = 26'h00000AA; alu_pout = 26'h0000055;
    @(negedge clk);
    alu_done = 2'b00;
    check("ch0_datainA", datain_a_a, 16'h00AA);
    check("ch0_status", status_a, 16'h0001);
    @(negedge clk);
    check("held_start_no_relaunch", status_a, 16'h0001);
    io_control = 16'h0000;
    @(negedge clk);

    // Single op on channel 1, done sampled on the 20th busy edge.
    io_control = 16'h0064; io_dataoutA = 16'hFFCE; io_dataoutB = 16'hFFC6;
    @(negedge clk);
    check("op1_x_hi", x_a[25:13], 13'h1FCE);
    check("op1_x_lo", x_a[12:0], 13'h0000);
    check("op1_y_hi", y_a[25:13], 13'h1FC6);
    check("op1_type", type_a, 3'b001);
    check("op1_busy_status", status_a, 16'h0002);
    io_dataoutA = 16'h0000; io_control = 16'h0040;
    repeat (4) @(negedge clk);
    alu_done = 2'b01;
    @(negedge clk);
    alu_done = 2'b00;
    check("other_done_ignored", status_a[1], 1'b1);
    repeat (14) @(negedge clk);
    alu_done = 2'b10; alu_fout = {13'h0123, 13'h0000}; alu_pout = {13'h0045, 13'h0000};
    @(negedge clk);
    alu_done = 2'b00;
    check("op1_datainA", datain_a_a, 16'h0123);
    check("op1_datainB", datain_b_a, 16'h0045);
    check("op1_status", status_a, 16'h0101);
    io_control = 16'h0000;
    @(negedge clk);

    // Watchdog on the TIMEOUT=8 instance.
    io_control = 16'h0020;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (start_b != 2'b00) n++;
    end
    check("tmo_start_cycles", n, 8);
    check("tmo_status", status_b, 16'h0004);
    check("tmo_datainA_kept", datain_a_b, 16'h00AA);
    check("tmo_datainB_kept", datain_b_b, 16'h0055);
    alu_done = 2'b01; alu_fout = 26'h0001ABC; alu_pout = 26'h0000F0F;
    @(negedge clk);
    alu_done = 2'b00;
    check("long_op_status", status_a, 16'h0001);
    check("long_op_datainA", datain_a_a, 16'h1ABC);
    io_control = 16'h0000;
    @(negedge clk);

    // Bad channel, then a one-cycle flag clear.
    io_control = 16'h00E0;
    @(negedge clk);
    check("bad_status_a", status_a, 16'h0009);
    check("bad_no_start", start_a, 2'b00);
    check("bad_status_b", status_b, 16'h000C);
    io_control = 16'h8000;
    @(negedge clk);
    check("clear_status_a", status_a, 16'h0000);
    check("clear_status_b", status_b, 16'h0000);
    io_control = 16'h0000;
    @(negedge clk);

    // Overrun, then done together with clear.
    io_control = 16'h0060; io_dataoutA = 16'h0111; io_dataoutB = 16'h0222;
    @(negedge clk);
    io_control = 16'h0040;
    @(negedge clk);
    io_control = 16'h0060; io_dataoutA = 16'h0333;
    @(negedge clk);
    check("ovr_status", status_a, 16'h0012);
    check("ovr_x_kept", x_a[25:13], 13'h0111);
    check("ovr_y_kept", y_a[25:13], 13'h0222);
    alu_done = 2'b10; alu_fout = {13'h0777, 13'h0000}; alu_pout = {13'h0666, 13'h0000};
    io_control = 16'h8060;
    @(negedge clk);
    alu_done = 2'b00;
    check("done_with_clear", status_a, 16'h0101);
    check("done_with_clear_dat", datain_a_a, 16'h0777);
    io_control = 16'h0000;
    @(negedge clk);

    // Done on the same edge the watchdog would fire: done wins.
    io_control = 16'h0020;
    repeat (8) @(negedge clk);
    alu_done = 2'b01; alu_fout = 26'h0000042; alu_pout = 26'h0000013;
    @(negedge clk);
    alu_done = 2'b00;
    check("done_beats_tmo", status_b, 16'h0001);
    check("done_beats_tmo_dat", datain_a_b, 16'h0042);
    io_control = 16'h0000;
    @(negedge clk);

    // Reset in the middle of an operation.
    io_control = 16'h0064; io_dataoutA = 16'h0abc;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_start", start_a, 2'b00);
    check("midrst_status", status_a, 16'h0000);
    check("midrst_datainA", datain_a_a, 16'h0000);
    check("midrst_x", x_a, 26'h0000000);
    io_control = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end

endmodule
